aes_round_ctrl: RTL and testbench

Sequencing controller for the iterative AES-128 encryption datapath. Accepts one block request at a time and drives the datapath's load and round-enable strobes, round index, final-round flag and round constant. Captures the datapath state after the last round into a registered `data_out` and presents it on a valid/ready handshake. Sits between the block-request source and the shared round/key-expansion datapath.

---
 rtl/aes_round_ctrl.sv | 150 +++++++++++++++
 tb/tb_aes_round_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: sequencing controller for an iterative AES-128 round datapath.
// Walks IDLE -> LOAD -> ROUND x NR -> DONE. It drives registered load/round strobes,
// the round index, the final-round flag and the key-expansion round constant. It then
// captures the datapath result into data_out behind a valid/ready handshake.
// Optional feature: define AES_CTRL_ABORT_EN to add the 'abort' input.
module aes_round_ctrl #(
  parameter int NR = 10,
  parameter int W  = 128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic         in_ready,
  input  logic         hold,
`ifdef AES_CTRL_ABORT_EN
  input  logic         abort,
`endif
  output logic         load,
  output logic         round_en,
  output logic [3:0]   round_idx,
  output logic         final_round,
  output logic [7:0]   rcon,
  input  logic [W-1:0] ds_state,
  output logic [W-1:0] data_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  // AES-128 has exactly ten rounds; any other count is rejected at elaboration.
  if (NR != 10) begin : g_bad_nr
    $error("aes_round_ctrl: NR must be 10 for AES-128");
  end

  state_e         state_q, state_d;
  logic           load_q, load_d;
  logic           round_en_q, round_en_d;
  logic [3:0]     round_idx_q, round_idx_d;
  logic [7:0]     rcon_q, rcon_d;
  logic [W-1:0]   data_out_q, data_out_d;
  logic           abort_w;

`ifdef AES_CTRL_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // GF(2^8) doubling: the rcon sequence is 01 followed by repeated xtime.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // Next-state logic. The strobes are registered, so hold is sampled at an edge and
  // suppresses the strobe for the cycle that follows. A round already strobed before
  // the hold edge has executed in the datapath. The stall therefore just freezes
  // round_idx/rcon and delays the next round.
  always_comb begin
    state_d     = state_q;
    load_d      = 1'b0;
    round_en_d  = 1'b0;
    round_idx_d = round_idx_q;
    rcon_d      = rcon_q;
    data_out_d  = data_out_q;
    case (state_q)
      S_IDLE: begin
        round_idx_d = '0;
        rcon_d      = '0;
        if (start) begin
          state_d = S_LOAD;
          load_d  = 1'b1;
        end
      end
      S_LOAD: begin
        if (abort_w) begin
          state_d = S_IDLE;
        end else if (!hold) begin
          state_d     = S_ROUND;
          round_en_d  = 1'b1;
          round_idx_d = 4'd1;
          rcon_d      = 8'h01;
        end
      end
      S_ROUND: begin
        if (abort_w) begin
          state_d     = S_IDLE;
          round_idx_d = '0;
          rcon_d      = '0;
        end else if (!hold) begin
          if (round_idx_q == LAST_ROUND) begin
            // ds_state carries the post-final-round value at this edge.
            state_d     = S_DONE;
            data_out_d  = ds_state;
            round_idx_d = '0;
            rcon_d      = '0;
          end else begin
            round_en_d  = 1'b1;
            round_idx_d = round_idx_q + 4'd1;
            rcon_d      = xtime(rcon_q);
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      load_q      <= 1'b0;
      round_en_q  <= 1'b0;
      round_idx_q <= '0;
      rcon_q      <= '0;
      data_out_q  <= '0;
    end else begin
      state_q     <= state_d;
      load_q      <= load_d;
      round_en_q  <= round_en_d;
      round_idx_q <= round_idx_d;
      rcon_q      <= rcon_d;
      data_out_q  <= data_out_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign load        = load_q;
  assign round_en    = round_en_q;
  assign round_idx   = round_idx_q;
  assign rcon        = rcon_q;
  assign data_out    = data_out_q;
  assign final_round = (state_q == S_ROUND) && (round_idx_q == LAST_ROUND);

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: directed plus randomized bench for aes_round_ctrl. It includes a
// behavioural AES-128 datapath (S-box built from GF(2^8) inverse + affine map) that
// follows the controller strobes. It also has a cycle-level expectation built from the
// rcon table and the round progression.
module tb_aes_round_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, hold = 1'b0, out_ready = 1'b0;
  logic in_ready, load, round_en, final_round, out_valid, busy;
  logic [3:0] round_idx;
  logic [7:0] rcon;
  logic [127:0] ds_state, data_out;
`ifdef AES_CTRL_ABORT_EN
  logic abort = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int stalls [11];
  int ready_delay = 0;
  logic [7:0] sbox [256];
  logic [7:0] rcon_tab [11] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
  logic [127:0] cur_pt = '0, cur_key = '0, exp_dout = '0;
  logic [127:0] dp_state = '0, dp_key = '0, dp_rk, dp_next;

  localparam logic [127:0] KAT_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KAT_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KAT_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  aes_round_ctrl #(.NR(10), .W(128)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_ready(in_ready), .hold(hold),
`ifdef AES_CTRL_ABORT_EN
    .abort(abort),
`endif
    .load(load), .round_en(round_en), .round_idx(round_idx), .final_round(final_round),
    .rcon(rcon), .ds_state(ds_state), .data_out(data_out), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = {sbox[w3[23:16]] ^ rc, sbox[w3[15:8]], sbox[w3[7:0]], sbox[w3[31:24]]};
    w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) t[r+4*c] = b[r + 4*((c+r)%4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
        t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
        t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
        t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    return o ^ rk;
  endfunction

  function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [127:0] key);
    logic [127:0] s, k;
    s = pt ^ key; k = key;
    for (int r = 1; r <= 10; r++) begin
      k = next_key(k, rcon_tab[r]);
      s = aes_round(s, k, r == 10);
    end
    return s;
  endfunction

  // Datapath model: follows load/round_en, and exposes next-state while round_en=1.
  always @(posedge clk) begin
    if (load) begin
      dp_state <= cur_pt ^ cur_key;
      dp_key   <= cur_key;
    end else if (round_en) begin
      dp_state <= dp_next;
      dp_key   <= dp_rk;
    end
  end

  always_comb begin
    dp_rk    = next_key(dp_key, rcon);
    dp_next  = aes_round(dp_state, dp_rk, final_round);
    ds_state = round_en ? dp_next : dp_state;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected signals during a LOAD, ROUND or stall cycle.
  task automatic chk_cycle(input string tag, input logic e_load, input logic e_ren,
                           input int e_idx, input logic [7:0] e_rcon);
    check({tag, ".load"}, 128'(load), 128'(e_load));
    check({tag, ".round_en"}, 128'(round_en), 128'(e_ren));
    check({tag, ".round_idx"}, 128'(round_idx), 128'(e_idx));
    check({tag, ".rcon"}, 128'(rcon), 128'(e_rcon));
    check({tag, ".final_round"}, 128'(final_round), 128'(e_idx == 10));
    check({tag, ".busy"}, 128'(busy), 128'(1));
    check({tag, ".in_ready"}, 128'(in_ready), 128'(0));
    check({tag, ".out_valid"}, 128'(out_valid), 128'(0));
  endtask

  task automatic chk_reset(input string tag);
    check({tag, ".load"}, 128'(load), 128'(0));
    check({tag, ".round_en"}, 128'(round_en), 128'(0));
    check({tag, ".out_valid"}, 128'(out_valid), 128'(0));
    check({tag, ".busy"}, 128'(busy), 128'(0));
    check({tag, ".final_round"}, 128'(final_round), 128'(0));
    check({tag, ".round_idx"}, 128'(round_idx), 128'(0));
    check({tag, ".rcon"}, 128'(rcon), 128'(0));
    check({tag, ".data_out"}, data_out, 128'(0));
    check({tag, ".in_ready"}, 128'(in_ready), 128'(1));
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    check({tag, ".in_ready_wait"}, 128'(in_ready), 128'(1));
  endtask

  // One block with the stall pattern in stalls[] (stalls[0] = LOAD, stalls[p] = round p)
  // and ready_delay cycles of out_ready=0 in DONE, with a stray start in that window.
  task automatic run_block(input logic [127:0] pt, input logic [127:0] key,
                           input logic [127:0] exp_ct, input string tag);
    wait_ready(tag);
    cur_pt = pt; cur_key = key;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_cycle($sformatf("%s.ld", tag), 1'b1, 1'b0, 0, 8'h00);
    for (int p = 0; p <= 10; p++) begin
      for (int s = 0; s < stalls[p]; s++) begin
        hold = 1'b1; start = 1'($urandom_range(0, 1));
        tick();
        chk_cycle($sformatf("%s.stall%0d", tag, p), 1'b0, 1'b0, p, rcon_tab[p]);
      end
      hold = 1'b0; start = 1'($urandom_range(0, 1));
      tick();
      if (p < 10) chk_cycle($sformatf("%s.r%0d", tag, p + 1), 1'b0, 1'b1, p + 1, rcon_tab[p+1]);
    end
    start = 1'b0;
    check({tag, ".done.out_valid"}, 128'(out_valid), 128'(1));
    check({tag, ".done.data_out"}, data_out, exp_ct);
    check({tag, ".done.round_en"}, 128'(round_en), 128'(0));
    check({tag, ".done.round_idx"}, 128'(round_idx), 128'(0));
    check({tag, ".done.rcon"}, 128'(rcon), 128'(0));
    check({tag, ".done.in_ready"}, 128'(in_ready), 128'(0));
    for (int d = 0; d < ready_delay; d++) begin
      out_ready = 1'b0; start = (d == 1); hold = 1'($urandom_range(0, 1));
      tick();
      check($sformatf("%s.wait%0d.out_valid", tag, d), 128'(out_valid), 128'(1));
      check($sformatf("%s.wait%0d.data_out", tag, d), data_out, exp_ct);
      check($sformatf("%s.wait%0d.in_ready", tag, d), 128'(in_ready), 128'(0));
    end
    start = 1'b0; hold = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, ".idle.in_ready"}, 128'(in_ready), 128'(1));
    check({tag, ".idle.out_valid"}, 128'(out_valid), 128'(0));
    check({tag, ".idle.busy"}, 128'(busy), 128'(0));
    check({tag, ".idle.data_out"}, data_out, exp_ct);
    exp_dout = exp_ct;
    $display("block %s: pt=%h key=%h ct=%h", tag, pt, key, exp_ct);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] pt, key, ct;
    logic [7:0] inv, sv;
    int acc [3];
    int n;
    // S-box: multiplicative inverse followed by the AES affine transform.
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sv = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox[x] = sv;
    end

    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    chk_reset("reset");

    // FIPS-197 known answer, no stalls.
    for (int i = 0; i < 11; i++) stalls[i] = 0;
    ready_delay = 0;
    run_block(KAT_PT, KAT_KEY, KAT_CT, "kat");

    // One stall cycle in LOAD, three at round 4: out_valid 15 cycles after acceptance.
    stalls[0] = 1; stalls[4] = 3;
    run_block(KAT_PT, KAT_KEY, KAT_CT, "hold");

    // Consumer back-pressure for five cycles with a stray start.
    for (int i = 0; i < 11; i++) stalls[i] = 0;
    ready_delay = 5;
    run_block(KAT_PT, KAT_KEY, KAT_CT, "done_wait");

    // Reset during round 6.
    ready_delay = 0;
    wait_ready("midrst");
    cur_pt = KAT_PT; cur_key = KAT_KEY;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk_cycle("midrst.r6", 1'b0, 1'b1, 6, 8'h20);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk_reset("midrst");
    exp_dout = '0;
    run_block(KAT_PT, KAT_KEY, KAT_CT, "after_rst");

    // Random blocks with random stall and back-pressure patterns.
    for (int b = 0; b < 4; b++) begin
      pt  = {$urandom, $urandom, $urandom, $urandom};
      key = {$urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < 11; i++) stalls[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      ready_delay = $urandom_range(0, 3);
      run_block(pt, key, aes_encrypt(pt, key), $sformatf("rand%0d", b));
    end

`ifdef AES_CTRL_ABORT_EN
    // Abort at round 3 (with hold also high): back to IDLE, previous data_out kept.
    for (int i = 0; i < 11; i++) stalls[i] = 0;
    ready_delay = 0;
    wait_ready("abort");
    cur_pt = {$urandom, $urandom, $urandom, $urandom}; cur_key = KAT_KEY;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    chk_cycle("abort.r3", 1'b0, 1'b1, 3, 8'h04);
    abort = 1'b1; hold = 1'b1;
    tick();
    abort = 1'b0; hold = 1'b0;
    chk_reset_abort: begin
      check("abort.in_ready", 128'(in_ready), 128'(1));
      check("abort.busy", 128'(busy), 128'(0));
      check("abort.round_en", 128'(round_en), 128'(0));
      check("abort.round_idx", 128'(round_idx), 128'(0));
      check("abort.rcon", 128'(rcon), 128'(0));
      check("abort.data_out", data_out, exp_dout);
    end
    n = 0;
    for (int i = 0; i < 15; i++) begin tick(); if (out_valid) n++; end
    check("abort.no_out_valid", 128'(n), 128'(0));
    run_block(KAT_PT, KAT_KEY, KAT_CT, "post_abort");
`endif

    // Back-to-back with out_ready tied high: acceptances spaced by
    // LOAD(1) + rounds(10) + DONE(1) + IDLE(1) cycles.
    out_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      pt  = {$urandom, $urandom, $urandom, $urandom};
      key = {$urandom, $urandom, $urandom, $urandom};
      ct  = aes_encrypt(pt, key);
      wait_ready($sformatf("b2b%0d", b));
      cur_pt = pt; cur_key = key;
      start = 1'b1; tick(); start = 1'b0;
      acc[b] = cyc;
      n = 0;
      while (!out_valid && n < 40) begin tick(); n++; end
      check($sformatf("b2b%0d.latency", b), 128'(cyc - acc[b]), 128'(11));
      check($sformatf("b2b%0d.data_out", b), data_out, ct);
      $display("block b2b%0d: accepted at cycle %0d ct=%h", b, acc[b], ct);
      tick();
    end
    check("b2b.spacing01", 128'(acc[1] - acc[0]), 128'(1 + 10 + 1 + 1));
    check("b2b.spacing12", 128'(acc[2] - acc[1]), 128'(1 + 10 + 1 + 1));
    out_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
